// File: rtl/param_tensor_core_if.sv
// Command/result bus of the parameterised tensor core: start, opcode, operands, status and result matrix.
interface param_tensor_core_if #(
  parameter int unsigned DIM        = 3,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                         should_start_tensor_core;
  logic [1:0]                   operation_select;
  logic signed [DATA_WIDTH-1:0] tensor_core_input1 [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] tensor_core_input2 [DIM][DIM];
  logic                         tensor_core_busy;
  logic                         tensor_core_done;
  logic                         tensor_core_saturated;
  logic signed [DATA_WIDTH-1:0] tensor_core_output [DIM][DIM];

  // Requester side: issues commands and operands, observes status and result.
  modport master (
    output should_start_tensor_core,
    output operation_select,
    output tensor_core_input1,
    output tensor_core_input2,
    input  tensor_core_busy,
    input  tensor_core_done,
    input  tensor_core_saturated,
    input  tensor_core_output
  );

  // Core side: accepts commands and operands, produces status and result.
  modport slave (
    input  should_start_tensor_core,
    input  operation_select,
    input  tensor_core_input1,
    input  tensor_core_input2,
    output tensor_core_busy,
    output tensor_core_done,
    output tensor_core_saturated,
    output tensor_core_output
  );

endinterface

// File: rtl/param_tensor_core.sv
// Parameterised DIM x DIM signed tensor core: matmul, add, relu and matmul-accumulate.
// Operands are captured on start; LANES result elements are produced per RUN cycle in
// row-major order, each saturated to DATA_WIDTH before it is written.
module param_tensor_core #(
  parameter int unsigned DIM        = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 1
) (
  input logic               tensor_core_clock,
  input logic               tensor_core_reset,
  param_tensor_core_if.slave bus
);

  localparam int unsigned NUM_ELEMS = DIM * DIM;
  localparam int unsigned IDX_W     = $clog2(NUM_ELEMS + LANES + 1);
  localparam int unsigned POS_W     = $clog2(DIM);
  localparam int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned WIDE_W    = 2 * DATA_WIDTH + $clog2(DIM) + 1;

  localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [1:0] OP_MATMUL = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_RELU   = 2'b10;
  localparam logic [1:0] OP_MAC    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   sat_q;

  logic [1:0]                   op_q;
  logic signed [DATA_WIDTH-1:0] a_q   [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] b_q   [DIM][DIM];
  logic signed [DATA_WIDTH-1:0] out_q [DIM][DIM];
  logic [IDX_W-1:0]             idx_q;

  logic accept_c;
  logic last_batch_c;

  logic                         lane_wr_c   [LANES];
  logic [POS_W-1:0]             lane_row_c  [LANES];
  logic [POS_W-1:0]             lane_col_c  [LANES];
  logic signed [DATA_WIDTH-1:0] lane_res_c  [LANES];
  logic                         lane_clip_c [LANES];

  assign accept_c     = (state_q == IDLE) && bus.should_start_tensor_core;
  assign last_batch_c = (idx_q + IDX_W'(LANES)) >= IDX_W'(NUM_ELEMS);

  // State and status register.
  always_ff @(posedge tensor_core_clock) begin
    if (tensor_core_reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; busy/done are decoded from the next state so they line up with RUN/DONE.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (last_batch_c) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Per-lane element computation at full width followed by saturation.
  always_comb begin
    logic [IDX_W-1:0]        elem;
    logic [POS_W-1:0]        row;
    logic [POS_W-1:0]        col;
    logic signed [WIDE_W-1:0] acc;
    elem = '0;
    row  = '0;
    col  = '0;
    acc  = '0;
    for (int l = 0; l < LANES; l++) begin
      elem = idx_q + IDX_W'(l);
      lane_wr_c[LANE_W'(l)]   = (state_q == RUN) && (elem < IDX_W'(NUM_ELEMS));
      row = '0;
      col = '0;
      if (lane_wr_c[LANE_W'(l)]) begin
        row = POS_W'(elem / IDX_W'(DIM));
        col = POS_W'(elem % IDX_W'(DIM));
      end
      lane_row_c[LANE_W'(l)] = row;
      lane_col_c[LANE_W'(l)] = col;

      acc = '0;
      unique case (op_q)
        OP_MATMUL, OP_MAC: begin
          if (op_q == OP_MAC) begin
            acc = WIDE_W'(out_q[row][col]);
          end
          for (int k = 0; k < DIM; k++) begin
            acc = acc + WIDE_W'(a_q[row][POS_W'(k)]) * WIDE_W'(b_q[POS_W'(k)][col]);
          end
        end
        OP_ADD: begin
          acc = WIDE_W'(a_q[row][col]) + WIDE_W'(b_q[row][col]);
        end
        OP_RELU: begin
          acc = a_q[row][col][DATA_WIDTH-1] ? '0 : WIDE_W'(a_q[row][col]);
        end
        default: begin
          acc = '0;
        end
      endcase

      lane_clip_c[LANE_W'(l)] = 1'b0;
      if (acc > SAT_MAX) begin
        lane_res_c[LANE_W'(l)]  = SAT_MAX[DATA_WIDTH-1:0];
        lane_clip_c[LANE_W'(l)] = 1'b1;
      end else if (acc < SAT_MIN) begin
        lane_res_c[LANE_W'(l)]  = SAT_MIN[DATA_WIDTH-1:0];
        lane_clip_c[LANE_W'(l)] = 1'b1;
      end else begin
        lane_res_c[LANE_W'(l)]  = acc[DATA_WIDTH-1:0];
      end
    end
  end

  // Operand capture, element index, result writeback and sticky saturation flag.
  always_ff @(posedge tensor_core_clock) begin
    if (tensor_core_reset) begin
      op_q  <= OP_MATMUL;
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      out_q <= '{default: '0};
      idx_q <= '0;
      sat_q <= 1'b0;
    end else if (accept_c) begin
      op_q  <= bus.operation_select;
      a_q   <= bus.tensor_core_input1;
      b_q   <= bus.tensor_core_input2;
      idx_q <= '0;
      sat_q <= 1'b0;
    end else if (state_q == RUN) begin
      idx_q <= idx_q + IDX_W'(LANES);
      for (int l = 0; l < LANES; l++) begin
        if (lane_wr_c[LANE_W'(l)]) begin
          out_q[lane_row_c[LANE_W'(l)]][lane_col_c[LANE_W'(l)]] <= lane_res_c[LANE_W'(l)];
          if (lane_clip_c[LANE_W'(l)]) begin
            sat_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.tensor_core_busy      = busy_q;
  assign bus.tensor_core_done      = done_q;
  assign bus.tensor_core_saturated = sat_q;
  assign bus.tensor_core_output    = out_q;

endmodule

// File: tb/tb_param_tensor_core.sv
// Bench for param_tensor_core: LANES=1 and LANES=2 instances driven identically and
// checked against a matrix-level reference model.
module tb_param_tensor_core;

  localparam int DIM  = 3;
  localparam int DW   = 8;
  localparam int N    = DIM * DIM;
  localparam int MAXV = (1 <<< (DW - 1)) - 1;
  localparam int MINV = -MAXV - 1;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  int mat_a   [DIM][DIM];
  int mat_b   [DIM][DIM];
  int ref_out [DIM][DIM];
  int ref_sat;

  always #5 clk = ~clk;

  param_tensor_core_if #(.DIM(DIM), .DATA_WIDTH(DW)) bus_l1 ();
  param_tensor_core_if #(.DIM(DIM), .DATA_WIDTH(DW)) bus_l2 ();

  param_tensor_core #(.DIM(DIM), .DATA_WIDTH(DW), .LANES(1)) dut_l1 (
    .tensor_core_clock (clk),
    .tensor_core_reset (rst),
    .bus               (bus_l1)
  );

  param_tensor_core #(.DIM(DIM), .DATA_WIDTH(DW), .LANES(2)) dut_l2 (
    .tensor_core_clock (clk),
    .tensor_core_reset (rst),
    .bus               (bus_l2)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int v, inout int flag);
    if (v > MAXV) begin flag = 1; return MAXV; end
    if (v < MINV) begin flag = 1; return MINV; end
    return v;
  endfunction

  // Reference: whole-matrix result of one operation on the operands in mat_a/mat_b.
  task automatic model_op(input int op);
    int nxt [DIM][DIM];
    int s;
    ref_sat = 0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        s = 0;
        case (op)
          0, 3: begin
            for (int k = 0; k < DIM; k++) s += mat_a[r][k] * mat_b[k][c];
            if (op == 3) s += ref_out[r][c];
          end
          1: s = mat_a[r][c] + mat_b[r][c];
          default: s = (mat_a[r][c] < 0) ? 0 : mat_a[r][c];
        endcase
        nxt[r][c] = clip(s, ref_sat);
      end
    ref_out = nxt;
  endtask

  task automatic drive_operands(input logic [1:0] op);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        bus_l1.tensor_core_input1[r][c] = DW'(mat_a[r][c]);
        bus_l1.tensor_core_input2[r][c] = DW'(mat_b[r][c]);
        bus_l2.tensor_core_input1[r][c] = DW'(mat_a[r][c]);
        bus_l2.tensor_core_input2[r][c] = DW'(mat_b[r][c]);
      end
    bus_l1.operation_select = op;
    bus_l2.operation_select = op;
  endtask

  task automatic drive_noise();
    logic [DW-1:0] v;
    logic [1:0] op;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        v = DW'($urandom);
        bus_l1.tensor_core_input1[r][c] = v;
        bus_l2.tensor_core_input1[r][c] = v;
        v = DW'($urandom);
        bus_l1.tensor_core_input2[r][c] = v;
        bus_l2.tensor_core_input2[r][c] = v;
      end
    op = 2'($urandom);
    bus_l1.operation_select = op;
    bus_l2.operation_select = op;
  endtask

  task automatic set_start(input logic v);
    bus_l1.should_start_tensor_core = v;
    bus_l2.should_start_tensor_core = v;
  endtask

  task automatic check_state(input string name);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        check($sformatf("%s_l1_out[%0d][%0d]", name, r, c), bus_l1.tensor_core_output[r][c], ref_out[r][c]);
        check($sformatf("%s_l2_out[%0d][%0d]", name, r, c), bus_l2.tensor_core_output[r][c], ref_out[r][c]);
      end
    check({name, "_l1_sat"}, 32'(bus_l1.tensor_core_saturated), ref_sat);
    check({name, "_l2_sat"}, 32'(bus_l2.tensor_core_saturated), ref_sat);
  endtask

  // One operation: start pulse (held through RUN/DONE when noisy, with changing inputs),
  // then busy length, single done pulse and its timing, then the result.
  task automatic run_op(input string name, input logic [1:0] op, input bit noisy);
    int busy1, busy2, done1, done2, at1, at2;
    busy1 = 0; busy2 = 0; done1 = 0; done2 = 0; at1 = -1; at2 = -1;
    @(negedge clk);
    drive_operands(op);
    model_op(int'(op));
    set_start(1'b1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (!noisy || i == 6) set_start(1'b0);
      if (noisy && i < 6) drive_noise();
      if (bus_l1.tensor_core_busy === 1'b1) busy1++;
      if (bus_l2.tensor_core_busy === 1'b1) busy2++;
      if (bus_l1.tensor_core_done === 1'b1) begin done1++; at1 = i; end
      if (bus_l2.tensor_core_done === 1'b1) begin done2++; at2 = i; end
    end
    check({name, "_l1_busy_cycles"}, busy1, N);
    check({name, "_l2_busy_cycles"}, busy2, (N + 1) / 2);
    check({name, "_l1_done_pulses"}, done1, 1);
    check({name, "_l2_done_pulses"}, done2, 1);
    check({name, "_l1_done_cycle"}, at1, N);
    check({name, "_l2_done_cycle"}, at2, (N + 1) / 2);
    check_state(name);
  endtask

  task automatic fill(input int a_val, input int b_val);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        mat_a[r][c] = a_val;
        mat_b[r][c] = b_val;
      end
  endtask

  initial begin
    int busy_seen, done_seen;
    rst = 1'b1;
    set_start(1'b0);
    fill(0, 0);
    drive_operands(2'b00);
    ref_out = '{default: 0};
    ref_sat = 0;
    repeat (2) @(negedge clk);
    check("reset_l1_busy", 32'(bus_l1.tensor_core_busy), 0);
    check("reset_l2_busy", 32'(bus_l2.tensor_core_busy), 0);
    check("reset_l1_done", 32'(bus_l1.tensor_core_done), 0);
    check("reset_l2_done", 32'(bus_l2.tensor_core_done), 0);
    check_state("reset");
    rst = 1'b0;

    // Identity times 1..9.
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        mat_a[r][c] = (r == c) ? 1 : 0;
        mat_b[r][c] = r * DIM + c + 1;
      end
    run_op("ident_mm", 2'b00, 1'b0);

    // Saturation at both ends.
    fill(127, 127);
    run_op("sat_hi_mm", 2'b00, 1'b0);
    fill(-128, -128);
    run_op("sat_lo_add", 2'b01, 1'b0);

    // Relu, then clear via add of zeros, then accumulate twice.
    fill(0, 7);
    mat_a[0][0] = -5;
    mat_a[0][1] = 3;
    run_op("relu", 2'b10, 1'b0);
    fill(0, 0);
    run_op("clear_add", 2'b01, 1'b0);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        mat_a[r][c] = (r == c) ? 1 : 0;
        mat_b[r][c] = 1;
      end
    run_op("mac1", 2'b11, 1'b0);
    run_op("mac2", 2'b11, 1'b0);

    // Add 1..9 to itself while start is held through RUN and DONE with changing inputs.
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        mat_a[r][c] = r * DIM + c + 1;
        mat_b[r][c] = r * DIM + c + 1;
      end
    run_op("noisy_add", 2'b01, 1'b1);

    // Random operations and operands.
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) begin
          mat_a[r][c] = (t < 4) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 20)) - 10;
          mat_b[r][c] = (t < 4) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 20)) - 10;
        end
      run_op($sformatf("rand%0d", t), 2'($urandom_range(0, 3)), bit'(t % 2));
    end

    // Abort in the 4th RUN cycle with start also high on the reset edge.
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        mat_a[r][c] = r + c + 1;
        mat_b[r][c] = 2;
      end
    @(negedge clk);
    drive_operands(2'b00);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    set_start(1'b1);
    @(negedge clk);
    rst = 1'b0;
    set_start(1'b0);
    ref_out = '{default: 0};
    ref_sat = 0;
    check("abort_l1_busy", 32'(bus_l1.tensor_core_busy), 0);
    check("abort_l2_busy", 32'(bus_l2.tensor_core_busy), 0);
    check_state("abort");
    busy_seen = 0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_l1.tensor_core_done !== 1'b0 || bus_l2.tensor_core_done !== 1'b0) done_seen++;
      if (bus_l1.tensor_core_busy !== 1'b0 || bus_l2.tensor_core_busy !== 1'b0) busy_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_stays_idle", busy_seen, 0);
    run_op("after_abort_mm", 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
